// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared FSM state encoding and ALU NOP codes for the ALU arbiter
package alu_arb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
   localparam logic [6:0] ALU_NOP_OP = 7'd0;
   localparam logic [5:0] ALU_NOP_AR = 6'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker starting just after last_grant
module rr_arbiter #(
   parameter int N = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx,
   output logic          any
);
   logic [IW-1:0] idx;
   // search last_grant+1 .. last_grant+N (mod N) and keep the first hit
   always_comb begin
      grant_idx = '0;
      any = 1'b0;
      idx = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last_grant) + k) % N);
         if (!any && req[idx]) begin
            any = 1'b1;
            grant_idx = idx;
         end
      end
      grant_onehot = any ? N'(1) << grant_idx : '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU; ALU_ARB_LOCK_EN adds req_lock
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W = 32,
   parameter int ID_W = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_op_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_op_b,
   input  logic [NUM_REQ*7-1:0]      req_op_code,
   input  logic [NUM_REQ*6-1:0]      req_ar_code,
`ifdef ALU_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic [DATA_W-1:0]         alu_op_a,
   output logic [DATA_W-1:0]         alu_op_b,
   output logic [6:0]                alu_op_code,
   output logic [5:0]                alu_ar_code,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_flag_carry,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_carry
);
   if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_params
      $error("alu_arbiter: NUM_REQ must be 2..8 and ID_W must equal clog2(NUM_REQ)");
   end

   state_t              state;
   logic [ID_W-1:0]     last_grant, own_id, rr_idx, sel_idx;
   logic [NUM_REQ-1:0]  rr_onehot, sel_onehot;
   logic                rr_any, sel_any;

   rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
      .req          (req_valid),
      .last_grant   (last_grant),
      .grant_onehot (rr_onehot),
      .grant_idx    (rr_idx),
      .any          (rr_any)
   );

`ifdef ALU_ARB_LOCK_EN
   logic            locked;
   logic [ID_W-1:0] lock_id;
   logic            lock_hit;
   assign lock_hit   = locked && req_valid[lock_id];
   assign sel_idx    = lock_hit ? lock_id : rr_idx;
   assign sel_any    = lock_hit || rr_any;
   assign sel_onehot = lock_hit ? NUM_REQ'(1) << lock_id : rr_onehot;
`else
   assign sel_idx    = rr_idx;
   assign sel_any    = rr_any;
   assign sel_onehot = rr_onehot;
`endif

   // grant is offered only while idle and never during a reset cycle
   assign req_ready = (state == IDLE && !reset && sel_any) ? sel_onehot : '0;

   // IDLE latches the winner's operands, EXEC captures the ALU, RESP waits for the consumer
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         alu_op_a    <= '0;
         alu_op_b    <= '0;
         alu_op_code <= ALU_NOP_OP;
         alu_ar_code <= ALU_NOP_AR;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_data    <= '0;
         rsp_carry   <= 1'b0;
         last_grant  <= ID_W'(NUM_REQ - 1);
         own_id      <= '0;
`ifdef ALU_ARB_LOCK_EN
         locked      <= 1'b0;
         lock_id     <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (sel_any) begin
               alu_op_a    <= req_op_a[int'(sel_idx)*DATA_W +: DATA_W];
               alu_op_b    <= req_op_b[int'(sel_idx)*DATA_W +: DATA_W];
               alu_op_code <= req_op_code[int'(sel_idx)*7 +: 7];
               alu_ar_code <= req_ar_code[int'(sel_idx)*6 +: 6];
               own_id      <= sel_idx;
`ifdef ALU_ARB_LOCK_EN
               last_grant  <= lock_hit ? last_grant : sel_idx;
               locked      <= req_lock[sel_idx];
               lock_id     <= sel_idx;
`else
               last_grant  <= sel_idx;
`endif
               state       <= EXEC;
            end
            EXEC: begin
               rsp_data  <= alu_out;
               rsp_carry <= alu_flag_carry;
               rsp_id    <= own_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid   <= 1'b0;
               alu_op_a    <= '0;
               alu_op_b    <= '0;
               alu_op_code <= ALU_NOP_OP;
               alu_ar_code <= ALU_NOP_AR;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table, directed and randomized checks of alu_arbiter with an adder/xor stub ALU
module tb_alu_arbiter;
   import alu_arb_pkg::*;
   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  ar;
      logic [31:0] d;
      logic        c;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   vld, req_ready;
   logic [W-1:0]   opa [N];
   logic [W-1:0]   opb [N];
   logic [6:0]     opc [N];
   logic [5:0]     arc [N];
   logic [N*W-1:0] fa, fb;
   logic [N*7-1:0] fo;
   logic [N*6-1:0] fr;
   logic [W-1:0]   alu_op_a, alu_op_b, alu_out, rsp_data;
   logic [6:0]     alu_op_code;
   logic [5:0]     alu_ar_code;
   logic           alu_flag_carry, rsp_valid, rsp_ready, rsp_carry;
   logic [1:0]     rsp_id;
   int             nvec = 0, nerr = 0, mlast = N - 1;

   always_comb
      for (int i = 0; i < N; i++) begin
         fa[i*W +: W] = opa[i];
         fb[i*W +: W] = opb[i];
         fo[i*7 +: 7] = opc[i];
         fr[i*6 +: 6] = arc[i];
      end

   // stub ALU: ar_code 1 adds with carry out, anything else is xor
   always_comb
      {alu_flag_carry, alu_out} = (alu_ar_code == 6'd1) ? {1'b0, alu_op_a} + {1'b0, alu_op_b} : {1'b0, alu_op_a ^ alu_op_b};

   alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (vld),
      .req_ready      (req_ready),
      .req_op_a       (fa),
      .req_op_b       (fb),
      .req_op_code    (fo),
      .req_ar_code    (fr),
      .alu_op_a       (alu_op_a),
      .alu_op_b       (alu_op_b),
      .alu_op_code    (alu_op_code),
      .alu_ar_code    (alu_ar_code),
      .alu_out        (alu_out),
      .alu_flag_carry (alu_flag_carry),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_id         (rsp_id),
      .rsp_data       (rsp_data),
      .rsp_carry      (rsp_carry)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int next_grant(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [5:0] ar);
      return (ar == 6'd1) ? {1'b0, a} + {1'b0, b} : {1'b0, a ^ b};
   endfunction

   // waits for a grant, follows the operation through EXEC and RESP, then consumes the response
   task automatic serve(input int exp_id, input logic [31:0] ed, input logic ec, input int hold);
      int g, n;
      logic [31:0] ea;
      g = -1;
      n = 0;
      while (g < 0 && n < 40) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      end
      if (g < 0) begin
         chk("grant_timeout", 64'd0, 64'd1);
         return;
      end
      chk("grant_id", 64'(g), 64'(exp_id));
      chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
      ea = opa[g];
      @(posedge clk);
      #1 vld[g] = 1'b0;
      @(negedge clk);
      chk("exec_no_rsp", 64'(rsp_valid), 64'd0);
      chk("exec_op_a", 64'(alu_op_a), 64'(ea));
      @(negedge clk);
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(exp_id));
      chk("rsp_data", 64'(rsp_data), 64'(ed));
      chk("rsp_carry", 64'(rsp_carry), 64'(ec));
      repeat (hold) begin
         @(negedge clk);
         chk("hold_rsp", {31'd0, rsp_valid, rsp_carry, rsp_data}, {31'd0, 1'b1, ec, ed});
         chk("hold_id", 64'(rsp_id), 64'(exp_id));
         chk("hold_no_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("rsp_cleared", 64'(rsp_valid), 64'd0);
      chk("alu_nop", {alu_op_code, alu_ar_code, alu_op_a}, 64'd0);
      mlast = exp_id;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [5:0] ar);
      opa[i] = a;
      opb[i] = b;
      arc[i] = ar;
      opc[i] = 7'h33;
      vld[i] = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [5];
      logic [32:0] r;
      int e;
      tbl[0] = '{1, 32'h0000_0005, 32'h0000_0003, 6'd1, 32'h0000_0008, 1'b0};
      tbl[1] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 6'd1, 32'h0000_0000, 1'b1};
      tbl[2] = '{0, 32'h8000_0000, 32'h8000_0000, 6'd1, 32'h0000_0000, 1'b1};
      tbl[3] = '{3, 32'h0000_1234, 32'h0000_00FF, 6'd2, 32'h0000_12CB, 1'b0};
      tbl[4] = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 6'd1, 32'h8000_0000, 1'b0};
      vld = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         opa[i] = '0; opb[i] = '0; opc[i] = '0; arc[i] = '0;
      end
      // reset two cycles, then idle with a stray rsp_ready that must be ignored
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mlast = N - 1;
      for (int c = 0; c < 10; c++) begin
         rsp_ready = c[0];
         @(negedge clk);
         chk("idle_ready", 64'(req_ready), 64'd0);
         chk("idle_rsp", {rsp_valid, rsp_carry, rsp_id, rsp_data}, 64'd0);
         chk("idle_alu", {alu_op_code, alu_ar_code, alu_op_a}, 64'd0);
         chk("idle_alu_b", 64'(alu_op_b), 64'd0);
         chk("idle_state", 64'(dut.state), 64'(IDLE));
      end
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      // single-requester table vectors
      for (int t = 0; t < 5; t++) begin
         set_req(tbl[t].id, tbl[t].a, tbl[t].b, tbl[t].ar);
         serve(tbl[t].id, tbl[t].d, tbl[t].c, 0);
      end
      // all four valid after a fresh reset: order 0,1,2,3, then 0 again; backpressure on 2
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      mlast = N - 1;
      for (int i = 0; i < N; i++) set_req(i, 32'(i * 16 + 1), 32'(i + 2), 6'd1);
      for (int i = 0; i < N; i++) begin
         r = 33'(i * 16 + 1) + 33'(i + 2);
         serve(i, r[31:0], r[32], (i == 2) ? 5 : 0);
      end
      set_req(0, 32'hDEAD_0000, 32'h0000_BEEF, 6'd3);
      serve(0, 32'hDEAD_BEEF, 1'b0, 0);
      // reset while requester 1 is in EXEC: response dropped, requester 0 beats 2 afterwards
      set_req(1, 32'h1111_1111, 32'h2222_2222, 6'd1);
      @(negedge clk);
      chk("pre_reset_grant", 64'(req_ready), 64'b0010);
      @(posedge clk);
      #1 vld[1] = 1'b0;
      reset = 1'b1;
      set_req(2, 32'h0000_0009, 32'h0000_0001, 6'd1);
      set_req(0, 32'h0000_0004, 32'h0000_0004, 6'd1);
      @(negedge clk);
      chk("reset_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      mlast = N - 1;
      chk("reset_no_rsp", 64'(rsp_valid), 64'd0);
      chk("reset_state", 64'(dut.state), 64'(IDLE));
      serve(0, 32'h0000_0008, 1'b0, 0);
      serve(2, 32'h0000_000A, 1'b0, 1);
      // randomized traffic against the round-robin reference
      for (int it = 0; it < 60; it++) begin
         for (int i = 0; i < N; i++)
            if (!vld[i] && $urandom_range(0, 1) == 1)
               set_req(i, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 6'd1 : 6'($urandom_range(0, 63)));
         if (vld == '0) set_req(int'($urandom_range(0, N - 1)), $urandom, $urandom, 6'd1);
         e = next_grant(vld, mlast);
         r = alu_ref(opa[e], opb[e], arc[e]);
         serve(e, r[31:0], r[32], int'($urandom_range(0, 3)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
